parity_checker_stream: RTL and testbench

- Parametrised multi-lane parity checker with a valid/ready stream interface.
- Each beat carries NUM_LANES lanes. Each lane is DATA_W data bits plus one parity bit.
- The block checks every lane, strips the parity bits and forwards the data with per-lane error flags after a one-cycle register stage.
- Keeps error statistics (saturating count, per-lane sticky flags) and raises an alarm on runs of consecutive errored beats. Sits between a link receiver and downstream consumers.

---
 rtl/parity_chk_pkg.sv | 24 ++
 rtl/parity_alarm_fsm.sv | 76 +++++++
 rtl/parity_checker_stream.sv | 119 +++++++++++
 tb/tb_parity_checker_stream.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_chk_pkg.sv
// parity_chk_pkg: shared types and helpers for the multi-lane parity checker.
//   alarm_state_t : burst-error alarm FSM states
//   lane_w()      : lane width (data bits + one parity bit)
//   lane_parity() : per-lane parity error for a {parity, data} lane
package parity_chk_pkg;

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_ALARM} alarm_state_t;

  // Upper bound on lane width accepted by lane_parity(). Callers zero-extend
  // their lane into this width, which leaves the XOR reduction unchanged.
  localparam int MAX_LANE_W = 1024;

  function automatic int lane_w(input int data_w);
    return data_w + 1;
  endfunction

  // Returns 1 when the lane violates the selected parity:
  // even mode errors on an odd number of ones, odd mode on an even number.
  function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane,
                                       input logic                  odd);
    return (^lane) ^ odd;
  endfunction

endpackage

// File: rtl/parity_alarm_fsm.sv
// parity_alarm_fsm: counts consecutive errored beats and raises a sticky alarm.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : clears run counter and alarm, returns to ST_OK
//   beat_fire  : a beat was accepted this cycle
//   beat_err   : the accepted beat had at least one lane error
//   alarm      : registered, high while in ST_ALARM
module parity_alarm_fsm
  import parity_chk_pkg::*;
#(
  parameter int ALARM_THRESH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic beat_fire,
  input  logic beat_err,
  output logic alarm
);

  localparam int RUN_W = (ALARM_THRESH < 2) ? 1 : $clog2(ALARM_THRESH + 1);
  localparam logic [RUN_W-1:0] THRESH    = RUN_W'(ALARM_THRESH);
  localparam logic [RUN_W-1:0] THRESH_M1 = RUN_W'(ALARM_THRESH - 1);

  alarm_state_t     state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             alarm_q, alarm_d;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (clr) begin
      // clr wins over a beat accepted in the same cycle
      state_d = ST_OK;
      run_d   = '0;
    end else if (beat_fire) begin
      case (state_q)
        ST_OK: begin
          if (beat_err) begin
            run_d   = RUN_W'(1);
            state_d = (ALARM_THRESH == 1) ? ST_ALARM : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (beat_err) begin
            if (run_q < THRESH) run_d = run_q + RUN_W'(1);
            if (run_q >= THRESH_M1) state_d = ST_ALARM;
          end else begin
            run_d   = '0;
            state_d = ST_OK;
          end
        end
        ST_ALARM: ;  // latched until clr or rst
        default: begin
          state_d = ST_OK;
          run_d   = '0;
        end
      endcase
    end
    alarm_d = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OK;
      run_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;

endmodule

// File: rtl/parity_checker_stream.sv
// parity_checker_stream: multi-lane parity checker on a valid/ready stream.
// Each accepted beat is checked lane by lane, parity bits are stripped and the
// data plus per-lane error flags are presented one cycle later.
//   clk, rst              : clock, synchronous active-high reset
//   cfg_odd               : 0 even / 1 odd parity, sampled with each beat
//   clr                   : clears statistics and alarm
//   in_valid/in_ready     : input handshake; in_data lanes are {parity, data}
//   out_valid/out_ready   : output handshake; out_data, out_err per lane
//   err_count             : saturating count of errored beats
//   err_sticky            : per-lane sticky error flags
//   alarm                 : burst-error alarm (ALARM_THRESH consecutive errors)
module parity_checker_stream
  import parity_chk_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NUM_LANES    = 2,
  parameter int ERR_CNT_W    = 16,
  parameter int ALARM_THRESH = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_odd,
  input  logic                              clr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_LANES*(DATA_W+1)-1:0]   in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_LANES*DATA_W-1:0]       out_data,
  output logic [NUM_LANES-1:0]              out_err,
  output logic [ERR_CNT_W-1:0]              err_count,
  output logic [NUM_LANES-1:0]              err_sticky,
  output logic                              alarm
);

  localparam int LANE_W = lane_w(DATA_W);

  logic                          accept;
  logic                          beat_err;
  logic [NUM_LANES-1:0]          lane_err;
  logic [NUM_LANES*DATA_W-1:0]   lane_data;

  logic                          out_valid_q, out_valid_d;
  logic [NUM_LANES*DATA_W-1:0]   out_data_q, out_data_d;
  logic [NUM_LANES-1:0]          out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0]          err_count_q, err_count_d;
  logic [NUM_LANES-1:0]          err_sticky_q, err_sticky_d;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [LANE_W-1:0] lane;
    assign lane                         = in_data[i*LANE_W +: LANE_W];
    assign lane_data[i*DATA_W +: DATA_W] = lane[DATA_W-1:0];
    assign lane_err[i]                  = lane_parity(MAX_LANE_W'(lane), cfg_odd);
  end

  assign beat_err = |lane_err;
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;

    // A beat accepted alongside an output transfer keeps out_valid high.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_data;
      out_err_d   = lane_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Beats accepted during clr are forwarded but not counted.
    if (clr) begin
      err_count_d  = '0;
      err_sticky_d = '0;
    end else if (accept && beat_err) begin
      if (err_count_q != {ERR_CNT_W{1'b1}}) err_count_d = err_count_q + ERR_CNT_W'(1);
      err_sticky_d = err_sticky_q | lane_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= '0;
      err_count_q  <= '0;
      err_sticky_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  parity_alarm_fsm #(
    .ALARM_THRESH(ALARM_THRESH)
  ) u_alarm (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .beat_fire(accept),
    .beat_err (beat_err),
    .alarm    (alarm)
  );

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_checker_stream.sv
// Bench for parity_checker_stream: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
// A second instance with a 2-bit error counter shares the stimulus.
module tb_parity_checker_stream;

  logic        clk = 1'b0;
  logic        rst, cfg_odd, clr, in_valid, out_ready;
  logic [17:0] in_data;
  logic        in_ready, out_valid, alarm;
  logic [15:0] out_data;
  logic [1:0]  out_err, err_sticky;
  logic [15:0] err_count;
  logic        in_ready2, out_valid2, alarm2;
  logic [15:0] out_data2;
  logic [1:0]  out_err2, err_sticky2, err_count2;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b0;

  always #5 clk = ~clk;

  parity_checker_stream #(.DATA_W(8), .NUM_LANES(2), .ERR_CNT_W(16), .ALARM_THRESH(3)) dut (
    .clk(clk), .rst(rst), .cfg_odd(cfg_odd), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .err_count(err_count), .err_sticky(err_sticky), .alarm(alarm));

  parity_checker_stream #(.DATA_W(8), .NUM_LANES(2), .ERR_CNT_W(2), .ALARM_THRESH(3)) dut2 (
    .clk(clk), .rst(rst), .cfg_odd(cfg_odd), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_err(out_err2),
    .err_count(err_count2), .err_sticky(err_sticky2), .alarm(alarm2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 0;
  logic [15:0] m_data  = '0;
  logic [1:0]  m_err   = '0;
  int          m_cnt   = 0;
  int          m_cnt2  = 0;
  logic [1:0]  m_sticky = '0;
  bit          m_alarm = 0;
  int          m_consec = 0;

  // A lane is bad when its ones count (data + parity) has the wrong parity
  // for the selected mode.
  function automatic logic [1:0] model_err(input logic [17:0] d, input logic odd);
    logic [1:0] e;
    for (int i = 0; i < 2; i++) begin
      int ones;
      ones = $countones(d[i*9 +: 9]);
      e[i] = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_data = '0; m_err = '0; m_cnt = 0; m_cnt2 = 0;
      m_sticky = '0; m_alarm = 0; m_consec = 0;
    end else begin
      bit         acc;
      logic [1:0] e;
      acc = in_valid && (!m_valid || out_ready);
      e   = model_err(in_data, cfg_odd);
      if (clr) begin
        m_cnt = 0; m_cnt2 = 0; m_sticky = '0; m_alarm = 0; m_consec = 0;
      end else if (acc) begin
        if (e != 2'b00) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
          m_sticky |= e;
          m_consec++;
          if (m_consec >= 3) m_alarm = 1;
        end else begin
          m_consec = 0;
        end
      end
      if (acc) begin
        m_valid = 1;
        m_data  = {in_data[16:9], in_data[7:0]};
        m_err   = e;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_cmp) begin
      check("in_ready",   in_ready,   !rst && (!m_valid || out_ready));
      check("out_valid",  out_valid,  m_valid);
      check("out_data",   out_data,   m_data);
      check("out_err",    out_err,    m_err);
      check("err_count",  err_count,  m_cnt);
      check("err_sticky", err_sticky, m_sticky);
      check("alarm",      alarm,      m_alarm);
      check("err_count_w2", err_count2, m_cnt2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [8:0] l1, input logic [8:0] l0);
    in_data  = {l1, l0};
    in_valid = 1'b1;
  endtask

  initial begin
    rst = 1; cfg_odd = 0; clr = 0; in_valid = 0; out_ready = 1; in_data = '0;
    cyc();
    run_cmp = 1'b1;
    cyc(); cyc();
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_err_count", err_count, 16'd0);
    rst = 0;

    // S1: clean even-mode beat
    put({1'b0, 8'hAA}, {1'b0, 8'h55});
    cyc();
    check("s1_valid", out_valid, 1'b1);
    check("s1_data", out_data, 16'hAA55);
    check("s1_err", out_err, 2'b00);
    check("s1_cnt", err_count, 16'd0);
    check("s1_alarm", alarm, 1'b0);

    // S2: lane0 error, then a clean beat
    put({1'b0, 8'h0F}, {1'b1, 8'hAA});
    cyc();
    check("s2_err", out_err, 2'b01);
    check("s2_cnt", err_count, 16'd1);
    check("s2_sticky", err_sticky, 2'b01);
    put({1'b0, 8'hAA}, {1'b0, 8'h55});
    cyc();
    check("s2_clean_err", out_err, 2'b00);
    check("s2_clean_cnt", err_count, 16'd1);

    // S3: odd mode
    cfg_odd = 1;
    put({1'b0, 8'h01}, {1'b1, 8'h55});
    cyc();
    check("s3_ok", out_err, 2'b00);
    put({1'b0, 8'h01}, {1'b0, 8'h55});
    cyc();
    check("s3_bad", out_err, 2'b01);
    check("s3_cnt", err_count, 16'd2);
    cfg_odd = 0;

    // S4: backpressure holds the output and blocks input
    put({1'b0, 8'hAA}, {1'b0, 8'h55});
    cyc();
    out_ready = 0;
    put({1'b0, 8'h33}, {1'b0, 8'h0F});
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s4_in_ready", in_ready, 1'b0);
      check("s4_hold", out_data, 16'hAA55);
      cyc();
    end
    out_ready = 1;
    #1;
    check("s4_release_ready", in_ready, 1'b1);
    cyc();
    check("s4_next", out_data, 16'h330F);
    check("s4_next_valid", out_valid, 1'b1);

    // S5: alarm on three consecutive errored beats, then clr
    put({1'b1, 8'h00}, {1'b0, 8'h00});
    cyc();
    cyc();
    check("s5_alarm_2", alarm, 1'b0);
    cyc();
    check("s5_alarm_3", alarm, 1'b1);
    put({1'b0, 8'h00}, {1'b0, 8'h00});
    cyc();
    check("s5_alarm_hold", alarm, 1'b1);
    clr = 1;
    put({1'b1, 8'h00}, {1'b0, 8'h00});
    cyc();
    clr = 0;
    check("s5_clr_alarm", alarm, 1'b0);
    check("s5_clr_cnt", err_count, 16'd0);
    check("s5_clr_sticky", err_sticky, 2'b00);
    check("s5_clr_fwd_err", out_err, 2'b10);

    // S6: counter saturation, then reset with a pending beat
    repeat (5) cyc();
    check("s6_cnt16", err_count, 16'd5);
    check("s6_cnt2_sat", err_count2, 2'd3);
    in_valid  = 0;
    out_ready = 0;
    rst = 1;
    #1;
    check("s6_rst_in_ready", in_ready, 1'b0);
    cyc();
    check("s6_rst_valid", out_valid, 1'b0);
    check("s6_rst_cnt", err_count, 16'd0);
    check("s6_rst_cnt2", err_count2, 2'd0);
    check("s6_rst_sticky", err_sticky, 2'b00);
    rst = 0;
    out_ready = 1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      cfg_odd   = 1'($urandom % 2);
      clr       = ($urandom % 40) == 0;
      rst       = ($urandom % 300) == 0;
      in_data   = 18'($urandom);
      cyc();
    end

    rst = 0; clr = 0; in_valid = 0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
